rd_fifo_ctrl: RTL
=================

# rd_fifo_ctrl

Read-side pointer controller for the dual-clock FIFO, living entirely in the read clock domain. It:
- synchronises the write-side Gray pointer;
- maintains the binary read pointer that addresses the FIFO RAM;
- exports a registered Gray read pointer back to the write domain;
- generates empty, occupancy, almost-empty and underflow status.

It pairs with the write-side controller under the same one-slot-reserved convention: usable depth 2^ADDR_WDTH-1, no wrap bit.

## Interface
- ADDR_WDTH, 4, pointer/RAM address width
- SYNC_STAGES, 2, flop stages in the write-pointer synchronizer (>=2)
- AE_THRESH, 1, almost_empty asserted when level <= AE_THRESH
- clk  in  1  read clock
- rst_n  in  1  reset, asynchronous, active-low
- sync_rst_n  in  1  synchronous clear, active-low, read domain
- wr_ptr_gray  in  ADDR_WDTH  write pointer, Gray, from write domain (asynchronous)
- rd_en  in  1  read request; accepted only when !empty
- rd_ptr_gray  out  ADDR_WDTH  read pointer, Gray, registered, to write domain
- rd_ptr_bin  out  ADDR_WDTH  read pointer, binary; RAM read address of head entry
- empty  out  1  no data visible to reader
- level  out  ADDR_WDTH  occupancy as seen by reader, 0..2^ADDR_WDTH-1
- almost_empty  out  1  level <= AE_THRESH
- underflow  out  1  one-cycle pulse: rd_en seen while empty

## Operation
- Priority: rst_n > sync_rst_n > normal operation.
- Reset values under rst_n or sync_rst_n:
  - rd_ptr = 0, rd_ptr_gray = 0, all synchronizer flops = 0, underflow = 0.
  - Hence empty=1, level=0, almost_empty=1.
- Synchronizer: wr_ptr_gray is sampled into a SYNC_STAGES-deep flop chain, giving wr_gray_s. wr_bin_s = gray2bin(wr_gray_s), computed combinationally (MSB passthrough, then XOR cascade).
- Combinational status:
  - empty = (rd_ptr == wr_bin_s).
  - level = (wr_bin_s - rd_ptr) mod 2^ADDR_WDTH.
  - almost_empty = (level <= AE_THRESH).
- Accepted read (rd_en & !empty):
  - rd_ptr <= rd_ptr+1, with natural wrap 2^ADDR_WDTH-1 -> 0.
  - rd_ptr_gray <= bin2gray(rd_ptr+1) on the same edge.
- Otherwise rd_ptr and rd_ptr_gray hold.
- rd_ptr_gray is always a flop output. There is no combinational logic between it and the crossing, and it changes at most one bit per clk edge.
- underflow <= rd_en & empty; otherwise 0. No pointer change on underflow.
- sync_rst_n must be asserted in both domains for overlapping intervals. A one-sided clear is a system error and is not detected.

## Timing
- rd_ptr_bin is valid as RAM address in the cycle empty=0. Data latency is owned by the RAM; this block adds none.
- Write-to-visible latency: a wr_ptr_gray change deasserts empty / raises level after SYNC_STAGES clk edges (+1 edge worst case for sampling phase).
- Read-to-release latency: rd_ptr_gray updates at the edge accepting the read. Write-domain synchronisation delay is external.
- Reading the last entry: empty rises in the cycle after the accepting edge, unless wr_bin_s advanced on that same edge.
- Simultaneous read and sync-pointer advance: level = old level - 1 + increment. No lost update.
- Reset mid-operation: sync_rst_n with rd_en=1 ignores the read. Outputs are at reset values after that edge.
- Status is conservative. empty and level may lag true occupancy (pessimistic) and never over-report.

## Structure
- Package fifo_pkg holds:
  - functions bin2gray and gray2bin, parameterised on width;
  - the pointer width default.
- The write-side controller imports the same package.
- Sub-module gray_sync (SYNC_STAGES-deep bus synchronizer, async reset to 0, synchronous clear input) instantiated once for wr_ptr_gray. It is reused by the write side for rd_ptr_gray.
- Top holds the pointer register, status logic and underflow flop.

## Test plan
ADDR_WDTH=4, SYNC_STAGES=2, AE_THRESH=1 for all scenarios.
- Reset: assert rst_n low mid-cycle -> immediately rd_ptr_bin=0, rd_ptr_gray=0, empty=1, level=0, almost_empty=1, underflow=0.
- Fill/drain: wr_ptr_gray 0000->0010 (bin 3) -> empty=0 and level=3 after 2 edges. Three rd_en cycles -> rd_ptr_bin 0,1,2, rd_ptr_gray 0001,0011,0010, then empty=1, level=0.
- Underflow: rd_en=1 while empty -> rd_ptr unchanged, underflow=1 for exactly one cycle, then 0.
- Wrap-around: rd_ptr=14, wr_bin_s=1 -> level=3. Three reads -> rd_ptr_bin 14,15,0, rd_ptr_gray 1000,0000,0001, final rd_ptr=1, empty=1.
- Full visibility: wr_bin_s=15, rd_ptr=0 -> level=15, almost_empty=0. Reads step level 15->14 with no overflow aliasing.
- Sync clear: level=5, sync_rst_n=0 for one edge with rd_en=1 -> next cycle rd_ptr=0, rd_ptr_gray=0, empty=1, underflow=0. Stays empty until the write side restarts from 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared dual-clock FIFO helpers: pointer width default and Gray/binary conversion.
// The conversions work on a 32-bit container; callers zero-extend narrower
// pointers and truncate the result, which is exact because zero upper bits
// convert to zero upper bits in both directions.
package fifo_pkg;

    localparam int unsigned PTR_WDTH_DFLT = 4;
    localparam int unsigned CONV_WDTH     = 32;

    // Binary to reflected Gray code.
    function automatic logic [CONV_WDTH-1:0] bin2gray(input logic [CONV_WDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary: MSB passes through, lower bits are an XOR cascade from the top.
    function automatic logic [CONV_WDTH-1:0] gray2bin(input logic [CONV_WDTH-1:0] g);
        logic [CONV_WDTH-1:0] b;
        b[CONV_WDTH-1] = g[CONV_WDTH-1];
        for (int i = CONV_WDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage : fifo_pkg

// File: rtl/gray_sync.sv
// Multi-flop bus synchronizer for a Gray-coded pointer crossing clock domains.
// Ports:
//   clk        destination clock
//   rst_n      asynchronous active-low reset, clears every stage to 0
//   sync_rst_n synchronous active-low clear, clears every stage to 0
//   d          Gray-coded bus from the source domain (asynchronous)
//   q          synchronized bus, STAGES edges behind d
module gray_sync #(
    parameter int unsigned WDTH   = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            sync_rst_n,
    input  logic [WDTH-1:0] d,
    output logic [WDTH-1:0] q
);

    logic [WDTH-1:0] sync_q [STAGES];

    // Shift chain; only a single bit of d changes at a time, so any metastable
    // resolution lands on either the old or the new pointer value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                sync_q[i] <= '0;
            end
        end else if (!sync_rst_n) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= d;
            for (int i = 1; i < int'(STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q = sync_q[STAGES-1];

endmodule : gray_sync

// File: rtl/rd_fifo_ctrl.sv
// Read-side pointer controller of the dual-clock FIFO (read clock domain).
// One slot is reserved, so usable depth is 2^ADDR_WDTH-1 and no wrap bit is kept.
// Ports:
//   clk, rst_n     read clock, asynchronous active-low reset
//   sync_rst_n     synchronous active-low clear (read domain)
//   wr_ptr_gray    write pointer in Gray code from the write domain
//   rd_en          read request, accepted only when not empty
//   rd_ptr_gray    registered Gray read pointer to the write domain
//   rd_ptr_bin     binary read pointer, RAM address of the head entry
//   empty          no data visible to the reader
//   level          occupancy as seen by the reader
//   almost_empty   level <= AE_THRESH
//   underflow      one-cycle pulse when rd_en arrives while empty
module rd_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_WDTH   = PTR_WDTH_DFLT,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned AE_THRESH   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sync_rst_n,
    input  logic [ADDR_WDTH-1:0] wr_ptr_gray,
    input  logic                 rd_en,
    output logic [ADDR_WDTH-1:0] rd_ptr_gray,
    output logic [ADDR_WDTH-1:0] rd_ptr_bin,
    output logic                 empty,
    output logic [ADDR_WDTH-1:0] level,
    output logic                 almost_empty,
    output logic                 underflow
);

    logic [ADDR_WDTH-1:0] wr_gray_s;
    logic [ADDR_WDTH-1:0] wr_bin_s;
    logic [ADDR_WDTH-1:0] rd_ptr;
    logic [ADDR_WDTH-1:0] rd_ptr_inc;
    logic                 rd_accept;

    // Bring the write pointer into the read domain.
    gray_sync #(
        .WDTH   (ADDR_WDTH),
        .STAGES (SYNC_STAGES)
    ) u_wr_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .sync_rst_n (sync_rst_n),
        .d          (wr_ptr_gray),
        .q          (wr_gray_s)
    );

    // Status from the synchronized (possibly stale) write pointer; staleness
    // only ever under-reports occupancy.
    always_comb begin
        wr_bin_s     = ADDR_WDTH'(gray2bin(CONV_WDTH'(wr_gray_s)));
        empty        = (rd_ptr == wr_bin_s);
        level        = wr_bin_s - rd_ptr;
        almost_empty = (CONV_WDTH'(level) <= AE_THRESH);
        rd_accept    = rd_en & ~empty;
        rd_ptr_inc   = rd_ptr + ADDR_WDTH'(1);
    end

    // Binary and Gray pointers advance together so the exported Gray value
    // is a pure flop output that moves by one bit per accepted read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr      <= '0;
            rd_ptr_gray <= '0;
        end else if (!sync_rst_n) begin
            rd_ptr      <= '0;
            rd_ptr_gray <= '0;
        end else if (rd_accept) begin
            rd_ptr      <= rd_ptr_inc;
            rd_ptr_gray <= ADDR_WDTH'(bin2gray(CONV_WDTH'(rd_ptr_inc)));
        end
    end

    // Underflow pulse; the pointer is left untouched on a refused read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underflow <= 1'b0;
        end else if (!sync_rst_n) begin
            underflow <= 1'b0;
        end else begin
            underflow <= rd_en & empty;
        end
    end

    assign rd_ptr_bin = rd_ptr;

endmodule : rd_fifo_ctrl
